rom_dl_router: RTL and testbench
================================

ROM_DL_ROUTER -- requirements
Module: rom_dl_router

Interface
REQ-001 SHALL have parameter NUM_REGIONS, default 4, number of ROM regions (1..8).
REQ-002 SHALL have parameter ADDR_W, default 25, download address width.
REQ-003 SHALL have parameter REGION_BASE, default {25'h30000,25'h20000,25'h10000,25'h0}, packed NUM_REGIONS*ADDR_W start addresses, region 0 in LSBs, strictly ascending.
REQ-004 SHALL have parameter DIP_BYTES, default 8, captured DIP bytes (1..16).
REQ-005 SHALL have parameter RESET_HOLD, default 16, core-reset hold cycles after load completes (1..255).
REQ-006 SHALL have parameter WAVE_REQUIRED, default 1, 1 = core reset also waits for wave load.
REQ-007 clk_sys  in  1  system clock; all logic on rising edge.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 ioctl_download  in  1  download active level from HPS.
REQ-010 ioctl_wr  in  1  one-cycle byte write strobe.
REQ-011 ioctl_addr  in  ADDR_W  byte address.
REQ-012 ioctl_dout  in  8  byte data.
REQ-013 ioctl_index  in  8  stream type: 0 ROM, 1 title/mod, 2 wave, 254 DIP.
REQ-014 rgn_wr  out  NUM_REGIONS  one-hot region write strobe.
REQ-015 rgn_addr  out  ADDR_W  address relative to selected region base.
REQ-016 rgn_data  out  8  write data.
REQ-017 dip  out  DIP_BYTES*8  captured DIP bytes, byte 0 in LSBs.
REQ-018 mod  out  8  game-variant byte.
REQ-019 rom_done, wave_done  out  1 each  sticky completion flags.
REQ-020 addr_err  out  1  sticky: ROM write below REGION_BASE[0] dropped.
REQ-021 core_reset  out  1  active-high reset for the game core.

Function
REQ-022 ROM write (download high, ioctl_wr, index 0): exactly one rgn_wr bit SHALL pulse one cycle later with rgn_addr = ioctl_addr - base of highest region whose base <= ioctl_addr and rgn_data = ioctl_dout; latency exactly 1, no throttling.
REQ-023 Addresses above the last base SHALL route to region NUM_REGIONS-1; addresses below base 0 SHALL produce no strobe and set addr_err.
REQ-024 Index 254 writes with ioctl_addr < DIP_BYTES SHALL update dip byte ioctl_addr next cycle; others ignored.
REQ-025 Index 1 writes SHALL load mod; last byte wins.
REQ-026 Download falling edge SHALL be detected using registered previous download level and previous index; previous index 0 sets rom_done, 2 sets wave_done.
REQ-027 Download rising edge with index 0 SHALL clear rom_done and addr_err; with index 2 SHALL clear wave_done.
REQ-028 State machine IDLE/LOADING/HOLD/RUN: IDLE->LOADING on index-0 rising edge; LOADING->HOLD when ready = rom_done & (wave_done | !WAVE_REQUIRED); HOLD counts RESET_HOLD cycles then ->RUN; any state->LOADING on index-0 rising edge.
REQ-029 In IDLE, LOADING and HOLD, core_reset SHALL be 1; in RUN 0; registered output.
REQ-030 RUN->HOLD (counter restarted) if WAVE_REQUIRED and wave reload starts, re-entering RUN after wave_done.
REQ-031 ioctl_wr on the cycle download falls SHALL still be processed.
REQ-032 Non-ROM indices SHALL never pulse rgn_wr.

Reset
REQ-033 reset_n low SHALL asynchronously clear rgn_wr, rgn_addr, rgn_data, dip, mod, rom_done, wave_done, addr_err, hold counter, previous-level registers; state IDLE; core_reset 1.
REQ-034 Download already high at reset release SHALL be treated as a rising edge on the first clock.

Verification
REQ-035 Index-0 write addr 0x10005 data 0xA5 -> next cycle rgn_wr=4'b0010, rgn_addr=0x5, rgn_data=0xA5.
REQ-036 Index-0 write 0x4FFFF -> rgn_wr=4'b1000, rgn_addr=0x1FFFF; base 0 set to 0x100, write 0x10 -> no strobe, addr_err=1.
REQ-037 Index 254 bytes 0x11..0x18 at addr 0..7, then addr 8 = 0xFF -> dip=64'h1817161514131211.
REQ-038 ROM load ends, wave load ends 5 cycles later -> core_reset falls exactly RESET_HOLD+1 cycles after wave falling edge; WAVE_REQUIRED=0 -> after ROM falling edge.
REQ-039 reset_n pulsed low mid ROM load with download held high -> outputs cleared immediately, LOADING re-entered on first clock, core_reset stays 1.

Source files
------------

// File: rtl/rom_dl_router.sv
// ROM download router: steers HPS ioctl byte writes into per-region ROM write
// strobes, captures DIP and variant bytes, tracks load completion and holds
// the game core in reset until everything it needs has been loaded.
//
// Strobe semantics: rgn_wr is a single-cycle, one-hot pulse with no
// back-pressure. It is asserted the cycle after an accepted ioctl_wr.
// rgn_addr and rgn_data are valid while rgn_wr is high and hold their value
// otherwise.
module rom_dl_router #(
  parameter int                              NUM_REGIONS   = 4,
  parameter int                              ADDR_W        = 25,
  parameter logic [NUM_REGIONS*ADDR_W-1:0]   REGION_BASE   = {25'h30000, 25'h20000, 25'h10000, 25'h0},
  parameter int                              DIP_BYTES     = 8,
  parameter int                              RESET_HOLD    = 16,
  parameter int                              WAVE_REQUIRED = 1
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     ioctl_download,
  input  logic                     ioctl_wr,
  input  logic [ADDR_W-1:0]        ioctl_addr,
  input  logic [7:0]               ioctl_dout,
  input  logic [7:0]               ioctl_index,
  output logic [NUM_REGIONS-1:0]   rgn_wr,
  output logic [ADDR_W-1:0]        rgn_addr,
  output logic [7:0]               rgn_data,
  output logic [DIP_BYTES*8-1:0]   dip,
  output logic [7:0]               mod,
  output logic                     rom_done,
  output logic                     wave_done,
  output logic                     addr_err,
  output logic                     core_reset
);

  localparam logic [7:0] IDX_ROM  = 8'd0;
  localparam logic [7:0] IDX_MOD  = 8'd1;
  localparam logic [7:0] IDX_WAVE = 8'd2;
  localparam logic [7:0] IDX_DIP  = 8'd254;

  typedef enum logic [1:0] {IDLE, LOADING, HOLD, RUN} state_t;

  // state is kept as a named signal so checkers can bind to it directly
  state_t      state, state_next;
  logic [7:0]  hold_cnt, hold_cnt_next;
  logic        core_reset_next;

  logic        prev_download;
  logic [7:0]  prev_index;

  // A write in the cycle download drops is still honoured, so the window
  // covers both the current and the previous download level.
  logic active, wr_ok, rom_wr, rise, fall, rom_rise, wave_rise, ready;

  assign active    = ioctl_download | prev_download;
  assign wr_ok     = active & ioctl_wr;
  assign rom_wr    = wr_ok && (ioctl_index == IDX_ROM);
  assign rise      = ioctl_download & ~prev_download;
  assign fall      = ~ioctl_download & prev_download;
  assign rom_rise  = rise && (ioctl_index == IDX_ROM);
  assign wave_rise = rise && (ioctl_index == IDX_WAVE);
  assign ready     = rom_done & (wave_done | (WAVE_REQUIRED == 0));

  logic                sel_hit;
  logic [2:0]          sel_idx;
  logic [ADDR_W-1:0]   sel_base;

  // Region lookup: bases ascend, so the last matching entry is the highest
  // base not above the address.
  always_comb begin
    sel_hit  = 1'b0;
    sel_idx  = '0;
    sel_base = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (ioctl_addr >= REGION_BASE[i*ADDR_W +: ADDR_W]) begin
        sel_hit  = 1'b1;
        sel_idx  = 3'(i);
        sel_base = REGION_BASE[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // ROM write strobe, relative address and data, one cycle after the write
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rgn_wr   <= '0;
      rgn_addr <= '0;
      rgn_data <= '0;
    end else begin
      rgn_wr <= '0;
      if (rom_wr && sel_hit) begin
        rgn_wr   <= NUM_REGIONS'(1) << sel_idx;
        rgn_addr <= ioctl_addr - sel_base;
        rgn_data <= ioctl_dout;
      end
    end
  end

  // DIP and variant byte capture
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dip <= '0;
      mod <= '0;
    end else begin
      if (wr_ok && (ioctl_index == IDX_DIP)) begin
        for (int b = 0; b < DIP_BYTES; b++) begin
          if (ioctl_addr == ADDR_W'(b)) dip[b*8 +: 8] <= ioctl_dout;
        end
      end
      if (wr_ok && (ioctl_index == IDX_MOD)) mod <= ioctl_dout;
    end
  end

  // Sticky completion and error flags; a dropped write wins over a clear
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rom_done  <= 1'b0;
      wave_done <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      if (fall && (prev_index == IDX_ROM))       rom_done <= 1'b1;
      else if (rom_rise)                         rom_done <= 1'b0;
      if (fall && (prev_index == IDX_WAVE))      wave_done <= 1'b1;
      else if (wave_rise)                        wave_done <= 1'b0;
      if (rom_wr && !sel_hit)                    addr_err <= 1'b1;
      else if (rom_rise)                         addr_err <= 1'b0;
    end
  end

  // State, hold counter, edge-detect history and registered core reset.
  // prev_download clears to 0 so a download already high at reset release
  // is seen as a rising edge on the first clock.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      prev_download <= 1'b0;
      prev_index    <= '0;
      core_reset    <= 1'b1;
    end else begin
      state         <= state_next;
      hold_cnt      <= hold_cnt_next;
      prev_download <= ioctl_download;
      prev_index    <= ioctl_index;
      core_reset    <= core_reset_next;
    end
  end

  // Next-state logic. hold_cnt counts consecutive ready cycles, including
  // the one in which LOADING sees ready, so release always lands
  // RESET_HOLD+1 cycles after the completing download edge.
  always_comb begin
    state_next    = state;
    hold_cnt_next = hold_cnt;
    case (state)
      IDLE: ;
      LOADING: begin
        if (ready) begin
          state_next    = HOLD;
          hold_cnt_next = 8'd1;
        end
      end
      HOLD: begin
        if (!ready)                               hold_cnt_next = '0;
        else if (hold_cnt == 8'(RESET_HOLD))      state_next    = RUN;
        else                                      hold_cnt_next = hold_cnt + 8'd1;
      end
      RUN: begin
        if ((WAVE_REQUIRED != 0) && wave_rise) begin
          state_next    = HOLD;
          hold_cnt_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
    if (rom_rise) begin
      state_next    = LOADING;
      hold_cnt_next = '0;
    end
  end

  // Output logic: core held in reset everywhere except RUN
  always_comb begin
    core_reset_next = (state_next != RUN);
  end

endmodule

// File: tb/tb_rom_dl_router.sv
// Bench for rom_dl_router: two instances share the ioctl stimulus, one with
// default parameters and one with base 0 moved to 0x100, a short hold and no
// wave requirement.
module tb_rom_dl_router;

  localparam int         RH1    = 16;
  localparam int         RH2    = 5;
  localparam logic [99:0] BASES1 = {25'h30000, 25'h20000, 25'h10000, 25'h0};
  localparam logic [99:0] BASES2 = {25'h30000, 25'h20000, 25'h10000, 25'h100};

  // clock / reset
  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        reset_n;
  logic        ioctl_download, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout, ioctl_index;

  logic [3:0]  rgn_wr, rgn_wr_b;
  logic [24:0] rgn_addr, rgn_addr_b;
  logic [7:0]  rgn_data, rgn_data_b, mod, mod_b;
  logic [63:0] dip, dip_b;
  logic        rom_done, wave_done, addr_err, core_reset;
  logic        rom_done_b, wave_done_b, addr_err_b, core_reset_b;

  rom_dl_router #(.RESET_HOLD(RH1)) u_dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_index(ioctl_index), .rgn_wr(rgn_wr), .rgn_addr(rgn_addr),
    .rgn_data(rgn_data), .dip(dip), .mod(mod), .rom_done(rom_done),
    .wave_done(wave_done), .addr_err(addr_err), .core_reset(core_reset)
  );

  rom_dl_router #(.REGION_BASE(BASES2), .RESET_HOLD(RH2), .WAVE_REQUIRED(0)) u_dut_b (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_index(ioctl_index), .rgn_wr(rgn_wr_b), .rgn_addr(rgn_addr_b),
    .rgn_data(rgn_data_b), .dip(dip_b), .mod(mod_b), .rom_done(rom_done_b),
    .wave_done(wave_done_b), .addr_err(addr_err_b), .core_reset(core_reset_b)
  );

  // scoreboard state
  int          n_tests, n_fail;
  logic [36:0] exp_q[$];
  logic        exp_err_b;
  logic [7:0]  dip_model[8];
  logic [7:0]  mod_model;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference routing: scan bases from the top, first base not above addr wins.
  // Returns {one-hot, offset, 8'h0}; one-hot of zero means dropped.
  function automatic logic [36:0] route_exp(input logic [24:0] a, input logic [99:0] bases);
    logic [3:0]  hot   = '0;
    logic [24:0] off   = '0;
    logic        found = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (!found && a >= bases[i*25 +: 25]) begin
        found  = 1'b1;
        hot[i] = 1'b1;
        off    = a - bases[i*25 +: 25];
      end
    end
    return {hot, off, 8'h00};
  endfunction

  function automatic logic [63:0] dip_pack();
    logic [63:0] v = '0;
    for (int b = 0; b < 8; b++) v[b*8 +: 8] = dip_model[b];
    return v;
  endfunction

  // driver: ROM byte write, checked one cycle later on both instances
  task automatic rom_write(input logic [24:0] a, input logic [7:0] d);
    logic [36:0] e1, e2;
    e1 = route_exp(a, BASES1);
    e1[7:0] = d;
    e2 = route_exp(a, BASES2);
    e2[7:0] = d;
    exp_q.push_back(e1);
    if (e2[36:33] == 4'h0) exp_err_b = 1'b1;
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    e1 = exp_q.pop_front();
    check("rgn_wr", rgn_wr, e1[36:33]);
    check("rgn_addr", rgn_addr, e1[32:8]);
    check("rgn_data", rgn_data, e1[7:0]);
    check("rgn_wr_b", rgn_wr_b, e2[36:33]);
    if (e2[36:33] != 4'h0) check("rgn_addr_b", rgn_addr_b, e2[32:8]);
    check("addr_err_b", addr_err_b, exp_err_b);
    check("addr_err", addr_err, 1'b0);
  endtask

  // driver: non-ROM byte write, model updated from the index rules
  task automatic byte_write(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    if (ioctl_index == 8'd254 && a < 25'd8) dip_model[a[2:0]] = d;
    if (ioctl_index == 8'd1) mod_model = d;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    check("no_rgn_wr", {rgn_wr, rgn_wr_b}, 8'h00);
    check("dip", dip, dip_pack());
    check("mod", mod, mod_model);
  endtask

  logic [24:0] bnd[6];

  initial begin
    n_tests = 0; n_fail = 0; exp_err_b = 1'b0; mod_model = '0;
    for (int b = 0; b < 8; b++) dip_model[b] = '0;
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; ioctl_index = '0;
    #12;
    check("rst_core_reset", {core_reset, core_reset_b}, 2'b11);
    check("rst_rgn_wr", rgn_wr, 4'h0);
    check("rst_flags", {rom_done, wave_done, addr_err}, 3'b000);
    check("rst_dip_mod", {dip, mod}, 72'h0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);

    // ROM load: directed, boundaries, random
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    @(negedge clk_sys);
    check("load_core_reset", core_reset, 1'b1);
    rom_write(25'h10005, 8'hA5);
    rom_write(25'h4FFFF, 8'h5A);
    rom_write(25'h00010, 8'h77);
    bnd[0] = 25'h000FF; bnd[1] = 25'h00100; bnd[2] = 25'h0FFFF;
    bnd[3] = 25'h2FFFF; bnd[4] = 25'h30000; bnd[5] = 25'h0;
    for (int i = 0; i < 6; i++) rom_write(bnd[i], 8'($urandom_range(0, 255)));
    for (int i = 0; i < 30; i++) begin
      rom_write(25'($urandom_range(0, 32'h4FFFF)), 8'($urandom_range(0, 255)));
      if (i % 3 == 0) begin
        @(negedge clk_sys);
        check("rgn_wr_pulse", {rgn_wr, rgn_wr_b}, 8'h00);
      end
    end

    // ROM ends with a write in the falling cycle; wave ends 5 cycles later
    ioctl_download = 1'b0;
    rom_write(25'h20003, 8'h3C);
    check("rom_done", {rom_done, rom_done_b}, 2'b11);
    for (int j = 0; j <= 5 + RH1 + 3; j++) begin
      check("core_reset_wave", core_reset, (j < 5 + RH1 + 1));
      check("core_reset_nowave", core_reset_b, (j < RH2 + 1));
      check("wave_done", wave_done, (j >= 5));
      if (j >= 1) check("wave_no_rgn_wr", {rgn_wr, rgn_wr_b}, 8'h00);
      ioctl_wr = 1'b0;
      if (j == 0) begin ioctl_download = 1'b1; ioctl_index = 8'd2; end
      if (j >= 1 && j <= 3) begin
        ioctl_wr = 1'b1; ioctl_addr = 25'(j); ioctl_dout = 8'($urandom_range(0, 255));
      end
      if (j == 4) ioctl_download = 1'b0;
      @(negedge clk_sys);
    end
    ioctl_wr = 1'b0;

    // DIP capture
    ioctl_index = 8'd254; ioctl_download = 1'b1;
    @(negedge clk_sys);
    for (int b = 0; b < 8; b++) byte_write(25'(b), 8'(8'h11 + b));
    byte_write(25'd8, 8'hFF);
    check("dip_vector", dip, 64'h1817161514131211);
    byte_write(25'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    check("run_core_reset", {core_reset, core_reset_b}, 2'b00);

    // variant byte, last write wins
    ioctl_index = 8'd1; ioctl_download = 1'b1;
    @(negedge clk_sys);
    for (int i = 0; i < 3; i++) byte_write(25'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    ioctl_download = 1'b0;
    @(negedge clk_sys);

    // wave reload while running
    ioctl_index = 8'd2; ioctl_download = 1'b1;
    for (int j = 0; j <= 4 + RH1 + 3; j++) begin
      @(negedge clk_sys);
      check("reload_core_reset", core_reset, (j < 4 + RH1 + 1));
      check("reload_core_reset_b", core_reset_b, 1'b0);
      check("reload_wave_done", wave_done, (j >= 4));
      if (j == 3) ioctl_download = 1'b0;
    end

    // ROM restart clears rom_done and addr_err
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    @(negedge clk_sys);
    exp_err_b = 1'b0;
    check("restart_rom_done", {rom_done, rom_done_b}, 2'b00);
    check("restart_addr_err_b", addr_err_b, 1'b0);
    check("restart_core_reset", {core_reset, core_reset_b}, 2'b11);
    check("restart_wave_done", wave_done, 1'b1);
    rom_write(25'h00003, 8'h42);

    // asynchronous reset mid-load with download held high
    #2 reset_n = 1'b0;
    #1;
    exp_err_b = 1'b0; mod_model = '0;
    for (int b = 0; b < 8; b++) dip_model[b] = '0;
    check("arst_rgn", {rgn_wr, rgn_data}, 12'h0);
    check("arst_dip_mod", {dip, mod}, 72'h0);
    check("arst_flags", {wave_done, addr_err_b}, 2'b00);
    check("arst_core_reset", {core_reset, core_reset_b}, 2'b11);
    #1 reset_n = 1'b1;
    @(negedge clk_sys);
    check("relaunch_core_reset", {core_reset, core_reset_b}, 2'b11);
    check("relaunch_rom_done", rom_done, 1'b0);
    ioctl_download = 1'b0;
    for (int j = 0; j <= RH2 + 3; j++) begin
      @(negedge clk_sys);
      check("relaunch_release_b", core_reset_b, (j < RH2 + 1));
      check("relaunch_hold", core_reset, 1'b1);
      if (j == 0) check("relaunch_done", {rom_done, rom_done_b}, 2'b11);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
